// File: rtl/intadd_arb_if.sv
// Bundle between the issue logic, the intadd_arb sequencer and the shared intadd unit.
// master = arbiter view; slave = requester/unit/consumer view.
interface intadd_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  // requester channels; requester k sits at index k
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][127:0]      req_src0, req_src1, req_src2;
  logic [NREQ-1:0][5:0]        req_prec;   // {precision_s2, precision_s1, precision_s0}
  logic [NREQ-1:0][2:0]        req_sign;   // {sign_s2, sign_s1, sign_s0}
  // intadd unit side
  logic [127:0] au_src_reg0, au_src_reg1, au_src_reg2;
  logic [1:0]   au_precision_s0, au_precision_s1, au_precision_s2;
  logic         au_sign_s0, au_sign_s1, au_sign_s2;
  logic         au_inst_valid;
  logic [127:0] au_dst_reg0, au_dst_reg1, au_st;
  // shared response channel
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [127:0]   rsp_dst0, rsp_dst1, rsp_st;

  modport master (
    input  req_valid, req_src0, req_src1, req_src2, req_prec, req_sign,
    output req_ready,
    output au_src_reg0, au_src_reg1, au_src_reg2,
    output au_precision_s0, au_precision_s1, au_precision_s2,
    output au_sign_s0, au_sign_s1, au_sign_s2, au_inst_valid,
    input  au_dst_reg0, au_dst_reg1, au_st,
    output rsp_valid, rsp_id, rsp_dst0, rsp_dst1, rsp_st,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_src0, req_src1, req_src2, req_prec, req_sign,
    input  req_ready,
    input  au_src_reg0, au_src_reg1, au_src_reg2,
    input  au_precision_s0, au_precision_s1, au_precision_s2,
    input  au_sign_s0, au_sign_s1, au_sign_s2, au_inst_valid,
    output au_dst_reg0, au_dst_reg1, au_st,
    input  rsp_valid, rsp_id, rsp_dst0, rsp_dst1, rsp_st,
    output rsp_ready
  );
endinterface

// File: rtl/intadd_arb.sv
// Round-robin arbiter/sequencer sharing one intadd unit among NREQ requesters.
// One operation in flight: IDLE (grant) -> ISSUE -> WAIT (LAT cycles) -> RESP.
// Optional: define INTADD_ARB_PERF_EN to add perf_op_cnt / perf_stall_cnt.
module intadd_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst,
  intadd_arb_if.master  bus
`ifdef INTADD_ARB_PERF_EN
  ,
  output logic [31:0]   perf_op_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;
  logic [127:0]   src0_q, src1_q, src2_q;
  logic [5:0]     prec_q;
  logic [2:0]     sign_q;
  logic [IDW-1:0] id_q;
  logic [127:0]   dst0_q, dst1_q, st_q;
  logic           rsp_valid_q, inst_valid_q;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  int             j;

  // round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  // ready only for the granted requester, only in IDLE, never while in reset
  always_comb begin
    bus.req_ready = '0;
    for (int k = 0; k < NREQ; k++)
      bus.req_ready[k] = (state == IDLE) && !rst && gnt_any && (gnt_idx == IDW'(k));
  end

  // sequencer FSM with all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      src0_q       <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      prec_q       <= '0;
      sign_q       <= '0;
      id_q         <= '0;
      dst0_q       <= '0;
      dst1_q       <= '0;
      st_q         <= '0;
      rsp_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          src0_q       <= bus.req_src0[gnt_idx];
          src1_q       <= bus.req_src1[gnt_idx];
          src2_q       <= bus.req_src2[gnt_idx];
          prec_q       <= bus.req_prec[gnt_idx];
          sign_q       <= bus.req_sign[gnt_idx];
          id_q         <= gnt_idx;
          rr_ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
          inst_valid_q <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          inst_valid_q <= 1'b0;
          cnt          <= CW'(LAT-1);
          state        <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            dst0_q      <= bus.au_dst_reg0;
            dst1_q      <= bus.au_dst_reg1;
            st_q        <= bus.au_st;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.au_src_reg0     = src0_q;
  assign bus.au_src_reg1     = src1_q;
  assign bus.au_src_reg2     = src2_q;
  assign bus.au_precision_s0 = prec_q[1:0];
  assign bus.au_precision_s1 = prec_q[3:2];
  assign bus.au_precision_s2 = prec_q[5:4];
  assign bus.au_sign_s0      = sign_q[0];
  assign bus.au_sign_s1      = sign_q[1];
  assign bus.au_sign_s2      = sign_q[2];
  assign bus.au_inst_valid   = inst_valid_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = id_q;
  assign bus.rsp_dst0        = dst0_q;
  assign bus.rsp_dst1        = dst1_q;
  assign bus.rsp_st          = st_q;

`ifdef INTADD_ARB_PERF_EN
  // completed operations and cycles where someone waits without a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_op_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready)
        perf_op_cnt <= perf_op_cnt + 32'd1;
      if ((|bus.req_valid) && !(|bus.req_ready))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
